elevator_ctrl_n: RTL
====================

Name: elevator_ctrl_n

Overview:
Parametrised elevator car controller for an N-floor building, successor to the fixed 4-floor fsm.
- Latches one-hot floor requests and serves them with a SCAN policy: keep the current direction while requests lie ahead, then reverse.
- Models travel time per floor and door dwell with cycle timers.
- Drives the car position, direction, door and busy outputs to the display and LED logic.

Parameters:
NUM_FLOORS, 4, number of floors, >=2; floors numbered 0..NUM_FLOORS-1.
FLOOR_W, $clog2(NUM_FLOORS), width of the floor output.
TRAVEL_CYCLES, 150000000, clk cycles to move one floor (1.5 s at 100 MHz); >=1.
DOOR_CYCLES, 100000000, clk cycles the door stays open per stop; >=1.
TIMER_W, $clog2(max(TRAVEL_CYCLES,DOOR_CYCLES)+1), width of the shared timer.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-low (0 = reset).
req  in  NUM_FLOORS  one-hot-or-more floor requests; a single-cycle pulse is sufficient.
floor  out  FLOOR_W  current car floor.
dir  out  2  00 idle, 01 up, 10 down; 11 never driven.
busy  out  1  1 whenever the state is not IDLE.
door_open  out  1  1 in the DOOR state.
pending  out  NUM_FLOORS  latched unserved requests.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, floor=0, dir=00, busy=0, door_open=0, pending=0, timer=0, last_dir=up. Reset overrides all activity, including mid-MOVE or mid-DOOR.
- Request latching:
  - Define eff = pending | req. Each cycle, pending <= eff, minus any bit cleared by service in that cycle.
  - A req arriving in the same cycle as arrival at that floor counts as pending at that floor.
- ahead/behind:
  - For up: ahead = any eff bit above floor; behind = any eff bit below floor.
  - For down: mirrored.
- IDLE (dir=00, busy=0):
  - eff[floor]=1: next state DOOR, clear that pending bit, timer=0.
  - Else, requests above and (last_dir==up or nothing below): MOVE up.
  - Else, requests below: MOVE down.
  - Else: stay IDLE.
  - Transition happens on the same edge the req is sampled (1-cycle latency).
- MOVE:
  - dir shows the current direction; timer counts 0..TRAVEL_CYCLES-1.
  - On the edge where timer==TRAVEL_CYCLES-1: floor +/-1, timer=0.
  - If eff[new floor] is set: go to DOOR and clear the bit. Otherwise continue MOVE in the same direction.
  - floor never leaves 0..NUM_FLOORS-1. A direction is only chosen toward an existing request, and pending bits are only cleared by service.
  - A req for the floor just departed is latched and served later.
- DOOR (door_open=1, busy=1, dir holds last direction):
  - Timer counts 0..DOOR_CYCLES-1.
  - A req for the current floor during DOOR restarts the timer (timer=0) and is not left pending.
  - At expiry:
    - Requests ahead: MOVE in the same direction.
    - Else requests behind: MOVE reversed and update last_dir.
    - Else: IDLE with dir=00.
- last_dir updates on every MOVE entry.
- At top floor, "ahead" for up is empty by construction; at floor 0 the same holds for down.

Optional Feature:
Macro ELEVATOR_ESTOP_EN.
- Defined: adds input port estop (1 bit, level).
- While estop==1:
  - Timer and floor freeze; state is held; busy=1; dir is held.
  - door_open is held, except that it forces 1 if estop is asserted during DOOR.
  - Requests are still latched.
- On estop deassert, the block resumes from the frozen timer value.
- Not defined: no estop port; behaviour exactly as above.

Test Plan:
(Bench uses NUM_FLOORS=4, TRAVEL_CYCLES=10, DOOR_CYCLES=5.)
- Reset then idle 20 cycles -> floor=0, dir=00, busy=0, door_open=0, pending=0 throughout.
- From floor 0, 1-cycle pulse req=4'b0100 -> dir=01 at the next edge; floor=1 after 10 cycles; floor=2 after 20 cycles. Then door_open=1 for 5 cycles, pending=0, then IDLE with dir=00.
- At floor 2 idle, req=4'b1001 in a single cycle (last_dir=up):
  - Serves floor 3 first: arrival 10 cycles later, door 5 cycles.
  - Then reverses: dir=10, reaches floor 0 after 30 cycles, opens door, returns to IDLE.
- During DOOR at floor 1, pulse req=4'b0010 at dwell cycle 3 -> door stays open 5 more cycles (8 total) and pending[1] stays 0.
- Reset asserted mid-MOVE at timer=6 -> next edge floor=0, dir=00, busy=0, pending=0. A req after reset restarts normally.
- With ELEVATOR_ESTOP_EN defined:
  - estop held 7 cycles mid-MOVE -> floor arrival is delayed by exactly 7 cycles.
  - A req pulsed during estop appears in pending.

Source files
------------

// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - N-floor SCAN elevator car controller with travel/door cycle timers.
// Optional emergency stop input enabled by defining ELEVATOR_ESTOP_EN.
module elevator_ctrl_n #(
  parameter int NUM_FLOORS    = 4,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 150000000,
  parameter int DOOR_CYCLES   = 100000000,
  parameter int TIMER_W       = $clog2(((TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES) + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    floor,
  output logic [1:0]            dir,
  output logic                  busy,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  localparam logic [NUM_FLOORS-1:0] FLOOR_ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d, next_floor;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic                    up_q, up_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d, clear_mask;
  logic [NUM_FLOORS-1:0]   eff, here_mask, next_mask;
  logic                    above, below, ahead, behind;
  logic                    travel_done, door_done, halt;

`ifdef ELEVATOR_ESTOP_EN
  assign halt = estop;
`else
  assign halt = 1'b0;
`endif

  assign eff         = pend_q | req;
  assign next_floor  = up_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
  assign here_mask   = FLOOR_ONE << floor_q;
  assign next_mask   = FLOOR_ONE << next_floor;
  assign travel_done = (timer_q == TIMER_W'(TRAVEL_CYCLES - 1));
  assign door_done   = (timer_q == TIMER_W'(DOOR_CYCLES - 1));

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (eff[i] && (i > int'(floor_q))) above = 1'b1;
      if (eff[i] && (i < int'(floor_q))) below = 1'b1;
    end
  end

  // Direction-relative view of the request set, judged against the last travel direction.
  assign ahead  = up_q ? above : below;
  assign behind = up_q ? below : above;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      timer_q <= '0;
      up_q    <= 1'b1;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      timer_q <= timer_d;
      up_q    <= up_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    timer_d    = timer_q;
    up_d       = up_q;
    clear_mask = '0;
    if (!halt) begin
      case (state_q)
        S_IDLE: begin
          if (|(eff & here_mask)) begin
            state_d    = S_DOOR;
            timer_d    = '0;
            clear_mask = here_mask;
          end else if (above && (up_q || !below)) begin
            state_d = S_MOVE;
            up_d    = 1'b1;
            timer_d = '0;
          end else if (below) begin
            state_d = S_MOVE;
            up_d    = 1'b0;
            timer_d = '0;
          end
        end
        S_MOVE: begin
          if (travel_done) begin
            floor_d = next_floor;
            timer_d = '0;
            if (|(eff & next_mask)) begin
              state_d    = S_DOOR;
              clear_mask = next_mask;
            end
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        S_DOOR: begin
          // A fresh call for this floor keeps the door open instead of queueing it.
          if (|(eff & here_mask)) begin
            timer_d    = '0;
            clear_mask = here_mask;
          end else if (door_done) begin
            timer_d = '0;
            if (ahead) begin
              state_d = S_MOVE;
            end else if (behind) begin
              state_d = S_MOVE;
              up_d    = !up_q;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    pend_d = eff & ~clear_mask;
  end

  always_comb begin
    floor     = floor_q;
    pending   = pend_q;
    busy      = (state_q != S_IDLE) || halt;
    door_open = (state_q == S_DOOR);
    if (state_q == S_IDLE) dir = 2'b00;
    else                   dir = up_q ? 2'b01 : 2'b10;
  end

endmodule
